// File: rtl/serial_adder_4bit.sv
// rtl/serial_adder_4bit.sv - bit-serial LSB-first adder with carry-out, signed overflow and accumulate mode
module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_acc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic [WIDTH-1:0] w_op_a_nxt;
    logic [WIDTH-1:0] w_op_b_nxt;
    logic             w_carry_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout_nxt;
    logic             w_ovf_nxt;
    logic             w_done_nxt;

    logic             w_bit_sum;
    logic             w_bit_carry;
    logic [WIDTH-1:0] w_res_shifted;

    // Single full-adder cell over the LSBs of the operand shift registers.
    assign w_bit_sum     = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_bit_carry   = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
    assign w_res_shifted = {w_bit_sum, {(WIDTH-1){1'b0}}} | (r_res >> 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_a_nxt  = r_op_a;
        w_op_b_nxt  = r_op_b;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    // Accumulate mode feeds the held result back as operand A.
                    w_op_a_nxt  = i_acc ? r_sum : i_a;
                    w_op_b_nxt  = i_b;
                    w_carry_nxt = i_cin;
                    w_cnt_nxt   = '0;
                    w_res_nxt   = '0;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_op_a_nxt  = r_op_a >> 1;
                w_op_b_nxt  = r_op_b >> 1;
                w_carry_nxt = w_bit_carry;
                w_res_nxt   = w_res_shifted;
                w_cnt_nxt   = r_cnt + CW'(1);
                if (r_cnt == LAST_BIT) begin
                    // r_carry here is the carry into the MSB.
                    w_sum_nxt   = w_res_shifted;
                    w_cout_nxt  = w_bit_carry;
                    w_ovf_nxt   = r_carry ^ w_bit_carry;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_op_a  <= w_op_a_nxt;
            r_op_b  <= w_op_b_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_res   <= w_res_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_busy = (r_state == S_BUSY);
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: doc/serial_adder_4bit.md
# serial_adder_4bit

Bit-serial two-operand adder for the mini-processor datapath, complementing the combinational subtractor on the addition side. It latches operands on a START request and adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flop. It then presents SUM, carry-out and signed-overflow flags with a one-cycle DONE pulse. An accumulate mode reuses the previous SUM as operand A, giving the ALU a low-area running-total path.

## Interface
- WIDTH, 4, operand/result width in bits (minimum 2)
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous reset, active low
- START  input  1  request; sampled only when idle
- ACC  input  1  sampled with START; 1 = use current SUM as operand A, ignore A
- A  input  WIDTH  operand A (unsigned or two's complement)
- B  input  WIDTH  operand B
- CIN  input  1  carry-in, sampled with START
- BUSY  output  1  high while bits are being processed
- DONE  output  1  one-cycle pulse when result registers update
- SUM  output  WIDTH  result, held until next completion
- COUT  output  1  carry out of the MSB
- OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- Two states, IDLE and BUSY; bit counter counts 0..WIDTH-1.
- IDLE, START=1 sampled: latch opA (A, or SUM if ACC=1), B and CIN into shift registers/carry flop; clear counter; go to BUSY.
- IDLE, START=0: remain idle; SUM/COUT/OVF hold.
- BUSY, each cycle: s = a0 ^ b0 ^ c; c_next = majority(a0,b0,c); shift s into the result shift register from the MSB side; shift opA and B right by one; increment counter.
- On the cycle with counter = WIDTH-1:
  - load the completed result into SUM;
  - COUT = final carry; OVF = carry into MSB XOR COUT;
  - assert DONE for the following cycle; return to IDLE.
- START while BUSY is ignored; no queueing. A, B, ACC and CIN are don't-care while BUSY.
- SUM, COUT and OVF never show partial results; they change only on a DONE edge or on reset.
- Arithmetic: modulo 2^WIDTH. SUM + 2^WIDTH*COUT = opA + B + CIN exactly.
- Reset (asynchronous, any time, including mid-operation):
  - state goes to IDLE and the counter, carry and shift registers clear;
  - BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0;
  - an aborted operation produces no DONE.

## Timing
- START sampled high at edge k: BUSY=1 from after edge k through edge k+WIDTH.
- After edge k+WIDTH: BUSY=0, DONE=1 for exactly one cycle, and SUM/COUT/OVF are valid.
- Latency: WIDTH+1 edges from START sample to DONE visible; 5 for WIDTH=4.
- START held high during the DONE cycle is accepted immediately (state is IDLE), giving a back-to-back throughput of one result per WIDTH+1 cycles.
- For START with ACC=1 in the DONE cycle, operand A is the SUM just produced.
- BUSY and DONE are never high together.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then START with A=5, B=3, CIN=0 → DONE 5 edges later; SUM=8, COUT=0, OVF=1; BUSY high for exactly 4 cycles.
- A=15, B=1, CIN=0 → SUM=0, COUT=1, OVF=0. Then A=7, B=0, CIN=1 → SUM=8, COUT=0, OVF=1.
- Accumulate: A=5, B=3 → SUM=8. Then START with ACC=1 in the DONE cycle, B=9, A=2 (ignored) → SUM=1, COUT=1, OVF=1, DONE exactly 5 cycles after the first DONE.
- START re-pulsed with A=1, B=1 on the 2nd BUSY cycle of an A=2, B=2 operation → single DONE with SUM=4; no second operation starts.
- RST_N low on the 3rd BUSY cycle of A=6, B=6 → BUSY, DONE, SUM, COUT and OVF all 0 immediately; no DONE afterwards. A fresh START with A=6, B=6 → SUM=12, COUT=0, OVF=1.
- Randomised sweep over all 512 combinations of A, B and CIN against the reference model opA+B+CIN → SUM, COUT and OVF match on every DONE.
